// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the 4-bit sync FIFO and fifo_uart_tx.
// master: the consumer popping words; slave: the FIFO answering the pops.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  modport master (output fifo_rd_en, input fifo_empty, input fifo_rd_data);
  modport slave  (input fifo_rd_en, output fifo_empty, output fifo_rd_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and serialises them as start / data LSB-first / stop frames.
// Optional even parity bit after the data when UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tx_enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [TMR_W-1:0]      r_bit_tmr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_tmr_done;
  logic                  w_in_bit;
  logic                  w_cnt_step;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  assign w_in_bit   = (r_state == START) || (r_state == DATA) ||
`ifdef UART_TX_PARITY_EN
                      (r_state == PARITY) ||
`endif
                      (r_state == STOP);
  assign w_tmr_done = w_in_bit && (r_bit_tmr == TMR_LAST);
  assign w_cnt_step = w_tmr_done && ((r_state == DATA) || (r_state == STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (tx_enable && !fifo.fifo_empty) w_next = POP;
      POP:   w_next = LOAD;
      LOAD:  w_next = START;
      START: if (w_tmr_done) w_next = DATA;
      DATA: begin
        if (w_tmr_done && (r_bit_cnt == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tmr_done) w_next = STOP;
`endif
      STOP:  if (w_tmr_done && (r_bit_cnt == STOP_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bit counter indexes data bits in DATA and stop bits in STOP; cleared on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_tmr <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (!w_in_bit || w_tmr_done) begin
        r_bit_tmr <= '0;
      end else begin
        r_bit_tmr <= r_bit_tmr + TMR_W'(1);
      end

      if (!w_in_bit) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_step) begin
        if (((r_state == DATA) && (r_bit_cnt == DATA_LAST)) ||
            ((r_state == STOP) && (r_bit_cnt == STOP_LAST))) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end

      if (r_state == LOAD) begin
        r_shift <= fifo.fifo_rd_data;
      end else if ((r_state == DATA) && w_tmr_done) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= ^fifo.fifo_rd_data;
    end
  end
`endif

  // Outputs decode only registered state, so reset drives tx high without a clock.
  always_comb begin
    tx              = 1'b1;
    fifo.fifo_rd_en = 1'b0;
    busy            = (r_state != IDLE);
    frame_done      = 1'b0;
    case (r_state)
      POP:    fifo.fifo_rd_en = 1'b1;
      START:  tx = 1'b0;
      DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = r_parity;
`endif
      STOP:   frame_done = w_tmr_done && (r_bit_cnt == STOP_LAST);
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: expected frames queued at push, checked per cycle on tx.
// Follows UART_TX_PARITY_EN so it matches whichever build is compiled.
module tb_fifo_uart_tx;

  localparam int DW  = 4;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DW + PB + SB;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_enable;
  logic tx, busy, frame_done;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_enable (tx_enable),
    .fifo      (bus.master),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, one pop per rd_en.
  logic [DW-1:0] mem [16];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic blk_empty = 1'b0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr) || blk_empty;

  always @(posedge clk) begin
    if (bus.fifo_rd_en === 1'b1 && wr_ptr != rd_ptr) begin
      bus.fifo_rd_data <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  int rd_cnt = 0;
  int last_rd_cyc = -100;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.fifo_rd_en === 1'b1) begin
      check_val("rd_en_while_empty", bus.fifo_empty, 1'b0);
      rd_cnt++;
      last_rd_cyc = cyc;
    end
  end

  logic [15:0] exp_q [$];

  function automatic logic [15:0] mk_frame(input logic [DW-1:0] w);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = w[i];
    if (PB == 1) f[1+DW] = ^w;
    return f;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(mk_frame(w));
  endtask

  int frames = 0;
  int gap = -1;
  logic gap_chk = 1'b0;

  initial begin : monitor
    logic [15:0] e;
    logic ab;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        gap = -1;
        continue;
      end
      if (tx === 1'b0) begin
        if (gap_chk && gap >= 0) check_val("gap_high_cycles", gap, 3);
        check_val("pop_to_start", cyc - last_rd_cyc, 2);
        if (exp_q.size() == 0) begin
          check_val("frame_expected", exp_q.size(), 1);
          repeat (64) begin
            if (tx !== 1'b0) break;
            @(negedge clk);
          end
          gap = -1;
        end else begin
          e  = exp_q.pop_front();
          ab = 1'b0;
          for (int b = 0; b < NB && !ab; b++) begin
            for (int c = 0; c < CPB && !ab; c++) begin
              if (b != 0 || c != 0) begin
                @(negedge clk);
                if (rst_n !== 1'b1) ab = 1'b1;
              end
              if (!ab) begin
                check_val("tx_bit", tx, e[b]);
                check_val("frame_done", frame_done, (b == NB-1 && c == CPB-1));
                check_val("busy_in_frame", busy, 1'b1);
              end
            end
          end
          if (!ab) begin
            frames++;
            gap = 0;
          end else begin
            gap = -1;
          end
        end
      end else begin
        check_val("frame_done_idle", frame_done, 1'b0);
        if (gap >= 0) gap++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 400; i++) begin
      if (frames >= target) break;
      tick(1);
    end
    check_val("frame_wait", frames >= target, 1'b1);
  endtask

  task automatic wait_pop(input int base);
    for (int i = 0; i < 100; i++) begin
      if (rd_cnt > base) break;
      tick(1);
    end
    check_val("pop_wait", rd_cnt > base, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int f0, r0;
    rst_n = 1'b0;
    tx_enable = 1'b0;
    bus.fifo_rd_data = '0;

    // Reset held with inputs moving
    push(4'h5);
    #2;
    for (int i = 0; i < 6; i++) begin
      tx_enable = i[0];
      blk_empty = i[1];
      tick(1);
      check_val("rst_tx", tx, 1'b1);
      check_val("rst_rd_en", bus.fifo_rd_en, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_frame_done", frame_done, 1'b0);
    end
    blk_empty = 1'b1;
    tx_enable = 1'b1;
    rst_n = 1'b1;
    tick(8);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_rd_cnt", rd_cnt, 0);
    check_val("idle_tx", tx, 1'b1);
    blk_empty = 1'b0;
    wait_frames(1);

    // Single frame
    r0 = rd_cnt;
    push(4'hA);
    wait_frames(2);
    check_val("single_pops", rd_cnt - r0, 1);

    // Parity patterns (plain frames in the default build)
    push(4'h7);
    wait_frames(3);
    push(4'hA);
    wait_frames(4);

    // Back-to-back
    tick(5);
    r0 = rd_cnt;
    gap = -1;
    gap_chk = 1'b1;
    push(4'h3);
    push(4'hC);
    wait_frames(6);
    tick(4);
    gap_chk = 1'b0;
    check_val("b2b_pops", rd_cnt - r0, 2);
    check_val("b2b_empty", bus.fifo_empty, 1'b1);

    // Enable dropped mid-frame
    tx_enable = 1'b0;
    r0 = rd_cnt;
    push(4'h5);
    push(4'h9);
    push(4'h6);
    tick(2);
    tx_enable = 1'b1;
    wait_pop(r0);
    tick(10);
    tx_enable = 1'b0;
    wait_frames(7);
    tick(20);
    check_val("drop_pops", rd_cnt - r0, 1);
    check_val("drop_remaining", wr_ptr - rd_ptr, 2);
    check_val("drop_busy", busy, 1'b0);

    // Reset during data bit 2 of 0x9
    f0 = frames;
    r0 = rd_cnt;
    tx_enable = 1'b1;
    wait_pop(r0);
    tick(13);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_tx", tx, 1'b1);
    check_val("async_busy", busy, 1'b0);
    check_val("async_rd_en", bus.fifo_rd_en, 1'b0);
    tick(3);
    rst_n = 1'b1;
    wait_frames(f0 + 1);
    tick(4);
    check_val("post_rst_pops", rd_cnt - r0, 2);
    check_val("post_rst_fifo", wr_ptr - rd_ptr, 0);
    check_val("post_rst_exp", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
